// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int PC_W    = 7;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEF = '0;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } fetch_state_t;

  // Instruction record handed to the decode stage.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_instr_t;

endpackage

// File: rtl/fetch_pipeline_unit_if.sv
// Fetch-stage bus: instruction-memory port plus the decode-side valid/stall/redirect link.
interface fetch_pipeline_unit_if;
  import fetch_pkg::*;

  logic [PC_W-1:0]    imem_addr;
  logic               imem_rd_en;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall_in;
  logic               redirect_in;
  logic [PC_W-1:0]    redirect_pc;
  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] instr_out;
  logic               valid_out;

  modport master (
    output imem_addr, imem_rd_en, pc_out, instr_out, valid_out,
    input  imem_rdata, stall_in, redirect_in, redirect_pc
  );

  modport slave (
    input  imem_addr, imem_rd_en, pc_out, instr_out, valid_out,
    output imem_rdata, stall_in, redirect_in, redirect_pc
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer for the fetch stage plus the decode-facing output mux.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_capture,
  input  logic         i_clear,
  input  fetch_instr_t i_rsp,
  input  logic         i_rsp_valid,
  output fetch_instr_t o_out,
  output logic         o_valid,
  output logic         o_hold_valid
);

  fetch_instr_t r_hold;
  logic         r_hold_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
    end else if (i_clear) begin
      r_hold_valid <= 1'b0;
    end else if (i_capture) begin
      r_hold       <= i_rsp;
      r_hold_valid <= 1'b1;
    end
  end

  // The held entry is always older than the live response, so it wins.
  always_comb begin
    o_out = '0;
    if (r_hold_valid)     o_out = r_hold;
    else if (i_rsp_valid) o_out = i_rsp;
  end

  assign o_valid      = r_hold_valid | i_rsp_valid;
  assign o_hold_valid = r_hold_valid;

endmodule

// File: rtl/fetch_pipeline_unit.sv
// Fetch stage: owns the PC, reads a 1-cycle synchronous imem, feeds decode.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module fetch_pipeline_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_pipeline_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       stall_count
`endif
);

  fetch_state_t    r_state;
  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_rsp_pc;
  logic            r_rsp_valid;

  logic            w_redirect;
  logic            w_stall;
  logic            w_capture;
  logic            w_release;
  logic            w_hold_clear;
  logic            w_hold_valid;
  logic            w_valid_out;
  fetch_instr_t    w_rsp;
  fetch_instr_t    w_out;

  assign w_redirect = bus.redirect_in;
  assign w_stall    = bus.stall_in;

  // Redirect target goes straight to memory so the refetch costs no bubble.
  assign bus.imem_addr  = w_redirect ? bus.redirect_pc : r_fetch_pc;
  assign bus.imem_rd_en = rst_n & (w_redirect | (r_state == S_BOOT) | ~w_stall);

  assign w_capture    = (r_state == S_RUN) & w_stall & r_rsp_valid & ~w_hold_valid & ~w_redirect;
  assign w_release    = (r_state == S_STALL) & ~w_stall & ~w_redirect;
  assign w_hold_clear = w_redirect | w_release;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_BOOT;
      r_fetch_pc  <= RESET_PC;
      r_rsp_pc    <= '0;
      r_rsp_valid <= 1'b0;
    end else if (w_redirect) begin
      r_state     <= S_RUN;
      r_fetch_pc  <= bus.redirect_pc + 1'b1;
      r_rsp_pc    <= bus.redirect_pc;
      r_rsp_valid <= 1'b1;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state     <= S_RUN;
          r_fetch_pc  <= RESET_PC + 1'b1;
          r_rsp_pc    <= RESET_PC;
          r_rsp_valid <= 1'b1;
        end
        S_RUN: begin
          if (!w_stall) begin
            r_fetch_pc  <= r_fetch_pc + 1'b1;
            r_rsp_pc    <= r_fetch_pc;
            r_rsp_valid <= 1'b1;
          end else begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_STALL;
          end
        end
        S_STALL: begin
          if (!w_stall) begin
            r_fetch_pc  <= r_fetch_pc + 1'b1;
            r_rsp_pc    <= r_fetch_pc;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RUN;
          end
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign w_rsp.pc    = r_rsp_pc;
  assign w_rsp.instr = bus.imem_rdata;

  fetch_skid_buffer u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_capture    (w_capture),
    .i_clear      (w_hold_clear),
    .i_rsp        (w_rsp),
    .i_rsp_valid  (r_rsp_valid),
    .o_out        (w_out),
    .o_valid      (w_valid_out),
    .o_hold_valid (w_hold_valid)
  );

  assign bus.pc_out    = w_out.pc;
  assign bus.instr_out = w_out.instr;
  assign bus.valid_out = w_valid_out;

`ifdef FETCH_PERF_CNT_EN
  logic w_accept;
  logic w_stalled;

  assign w_accept  = w_valid_out & ~w_stall;
  assign w_stalled = w_valid_out & w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (w_accept && fetch_count != 16'hFFFF)  fetch_count <= fetch_count + 16'd1;
      if (w_stalled && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_pipeline_unit.md
Name: fetch_pipeline_unit

Overview:
Fetch stage of the 32-bit ARM pipeline. Owns the program counter and issues word reads to the synchronous instruction memory (1-cycle read latency). Presents each returned instruction with its PC to the decode stage's pipeline unit through a valid/stall interface. Handles decode back-pressure with a one-entry skid buffer, and handles branch redirects by flushing the stage.

Parameters:
PC_W, 7, PC / instruction-memory word-address width (128 words)
INSTR_W, 32, instruction width
RESET_PC, 0, first address fetched after reset

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
imem_addr  output  PC_W  instruction-memory word address
imem_rd_en  output  1  read strobe; imem_rdata valid exactly one cycle later
imem_rdata  input  INSTR_W  read data
stall_in  input  1  decode cannot accept this cycle
redirect_in  input  1  branch taken; flush and refetch
redirect_pc  input  PC_W  branch target, sampled when redirect_in=1
pc_out  output  PC_W  PC of presented instruction (to decode pc_in)
instr_out  output  INSTR_W  presented instruction (to decode instr_in)
valid_out  output  1  pc_out/instr_out carry a real instruction

Behaviour:
- Registers:
  - fetch_pc (next address to read)
  - rsp_pc and rsp_valid (read in flight, data this cycle)
  - hold_pc, hold_instr, hold_valid (skid entry)
  - FSM state
- Reset (async, any cycle, including mid-stall or mid-redirect): state=S_BOOT, fetch_pc=RESET_PC, all valid bits 0.
  - Reset output values: imem_rd_en=0, valid_out=0, pc_out=0, instr_out=0.
- Output mux:
  - hold_valid=1: outputs come from the hold entry.
  - else: pc_out=rsp_pc, instr_out=imem_rdata.
  - valid_out = hold_valid | rsp_valid.
  - When valid_out=0, pc_out and instr_out are forced to 0.
- Accept: transfer occurs when valid_out & ~stall_in.
- FSM:
  - S_BOOT: one cycle. imem_rd_en=1, imem_addr=RESET_PC. Next: fetch_pc=RESET_PC+1, rsp_valid=1, rsp_pc=RESET_PC, go to S_RUN.
  - S_RUN:
    - stall_in=0: imem_rd_en=1 at fetch_pc; fetch_pc increments; rsp_pc<=fetch_pc; rsp_valid<=1.
    - stall_in=1: no read issued. If rsp_valid & ~hold_valid, capture rsp_pc/imem_rdata into the hold entry. rsp_valid<=0. Go to S_STALL.
  - S_STALL:
    - No reads issued while stall_in=1; the hold entry is stable.
    - When stall_in falls: the hold entry is accepted that cycle; a read at fetch_pc is issued the same cycle; hold_valid<=0; go to S_RUN.
    - No instruction is lost or duplicated across the stall.
- Redirect has highest priority in every state, including simultaneous with stall_in or in S_BOOT:
  - imem_addr = redirect_pc combinationally, imem_rd_en=1.
  - hold_valid<=0; rsp_valid<=1; rsp_pc<=redirect_pc; fetch_pc<=redirect_pc+1; go to S_RUN.
  - valid_out is still driven in the redirect cycle; decode ignores it.
  - Response appears at cycle N+1, giving a one-bubble-free refetch.
- PC arithmetic: modulo 2^PC_W; 127+1 wraps to 0, no flag.
- Latency: PC issued at cycle N appears on pc_out/instr_out at cycle N+1.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds 16-bit output ports fetch_count (increments on each accept) and stall_count (increments each cycle stall_in & valid_out).
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and their logic are absent.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum (S_BOOT, S_RUN, S_STALL)
  - PC_W/INSTR_W constants
  - RESET_PC default
  - the decode-stage instruction record type
- One sub-module, fetch_skid_buffer, holds the single hold entry and the output mux.

Test Plan:
- Reset release, imem(k)=32'hE000_0000+k, stall_in=0 -> addresses 0,1,2… issued from the first cycle; valid_out high from cycle 1 with pc_out=0, instr_out=32'hE000_0000, then pc 1, 2… on consecutive cycles.
- stall_in high for 3 cycles while pc_out=5 -> pc_out=5 and instr_out held constant; imem_rd_en=0 during the stall; after release, the sequence continues 6, 7 with no gap or repeat.
- redirect_in=1, redirect_pc=40 at cycle N -> imem_addr=40 at N; pc_out=40 at N+1, then 41; the hold entry is cleared.
- redirect_in and stall_in asserted together -> redirect wins; with stall held, pc_out=redirect_pc is held until stall_in drops.
- Run to pc 127 -> next pc_out=0; no X values on outputs.
- Assert rst_n low during S_STALL -> all outputs 0 immediately (asynchronously); after release, fetch restarts at RESET_PC.
